inst_fetch_unit: RTL

- Front end that supplies instruction words to the control unit over a valid/ready handshake.
- Owns the architectural fetch PC and issues 16-bit word reads to instruction memory over a req/ack interface.
- Buffers up to 2 fetched words, together with their addresses.
- Applies branch redirects (branch_en, pc_offset) coming back from the control unit: flushes the buffer and discards any in-flight read.

---
 rtl/inst_fetch_unit_if.sv | 26 ++
 rtl/inst_fetch_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory read port and
// the instruction valid/ready stream toward the control unit.
interface inst_fetch_unit_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        inst_valid;
    logic [15:0] instruction;
    logic [15:0] inst_pc;
    logic        inst_ready;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        output inst_valid, instruction, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        input  inst_valid, instruction, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, reads memory one
// word at a time into a small prefetch FIFO, and applies redirects.
module inst_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_unit_if.master   bus,
    input  logic                branch_en,
    input  logic [9:0]          pc_offset,
    input  logic [15:0]         branch_pc,
    output logic [15:0]         fetch_pc,
    output logic [1:0]          fsm_state
);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] word;
        logic [15:0] addr;
    } entry_t;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        buf_q [BUF_DEPTH];
    entry_t        buf_d [BUF_DEPTH];

    logic          pop;
    logic          push;
    logic          flush;
    logic [CW-1:0] cnt_ap;
    logic [15:0]   offset16;
    logic [15:0]   target;

    assign pop      = bus.inst_valid & bus.inst_ready;
    assign cnt_ap   = count_q - CW'(pop);
    assign offset16 = {{5{pc_offset[9]}}, pc_offset, 1'b0};
    assign target   = (branch_pc & 16'hFFFE) + 16'd2 + offset16;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (branch_en) begin
                    flush = 1'b1;
                    pc_d  = target;
                end else if (cnt_ap < CW'(BUF_DEPTH)) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (branch_en) begin
                        flush = 1'b1;
                        pc_d  = target;
                    end else begin
                        push = 1'b1;
                        pc_d = pc_q + 16'd2;
                    end
                end else if (branch_en) begin
                    flush   = 1'b1;
                    pc_d    = target;
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                // The in-flight read must still be acked before reuse.
                if (branch_en) begin
                    flush = 1'b1;
                    pc_d  = target;
                end
                if (bus.mem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        buf_d = buf_q;
        for (int i = 0; i < BUF_DEPTH - 1; i++) begin
            if (pop) buf_d[i] = buf_q[i+1];
        end
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (push && cnt_ap == CW'(i)) begin
                buf_d[i] = {bus.mem_rdata, addr_q};
            end
        end
        count_d = flush ? '0 : cnt_ap + CW'(push);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            pc_q    <= RESET_PC;
            count_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            buf_q   <= buf_d;
        end
    end

    assign bus.mem_req     = req_q;
    assign bus.mem_addr    = addr_q;
    assign bus.inst_valid  = (count_q != '0);
    assign bus.instruction = buf_q[0].word;
    assign bus.inst_pc     = buf_q[0].addr;
    assign fetch_pc        = pc_q;
    assign fsm_state       = state_q;
endmodule
